// File: rtl/bisr_weight_loader.sv
// Loads one weight tile into the BISR allocation block: init pulse, row stream, verdict wait,
// then either a remapped-row readout into the systolic array or a failure report.
module bisr_weight_loader #(
  parameter int unsigned SYSTOLIC_SIZE = 8,
  parameter int unsigned WEIGHT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  output logic                                  busy,
  input  logic                                  src_valid,
  output logic                                  src_ready,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] src_weights,
  output logic                                  alloc_start,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] alloc_weights,
  output logic                                  alloc_weight_valid,
  input  logic                                  recovery_done,
  input  logic                                  recovery_success,
  output logic [ADDR_WIDTH-1:0]                 read_addr,
  output logic                                  load_en,
  output logic                                  done,
  output logic                                  status_fail,
  output logic                                  status_timeout
);

  localparam int unsigned RowW = SYSTOLIC_SIZE * WEIGHT_WIDTH;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH:0]   RowCount = (ADDR_WIDTH + 1)'(SYSTOLIC_SIZE);
  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [TmoW-1:0]       TmoLimit = TmoW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StStream,
    StWaitDone,
    StReadout,
    StFinish
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [RowW-1:0]       weights_q, weights_d;
  logic                  wvalid_q, wvalid_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_cnt_q  <= '0;
      addr_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      weights_q  <= '0;
      wvalid_q   <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      weights_q  <= weights_d;
      wvalid_q   <= wvalid_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    addr_cnt_d  = addr_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    weights_d   = weights_q;
    wvalid_d    = 1'b0;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    busy        = (state_q != StIdle);
    src_ready   = 1'b0;
    alloc_start = 1'b0;
    load_en     = 1'b0;
    read_addr   = '0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = StInit;
        end
      end
      StInit: begin
        alloc_start = 1'b1;
        row_cnt_d   = '0;
        state_d     = StStream;
      end
      StStream: begin
        src_ready = (row_cnt_q < RowCount);
        tmo_cnt_d = '0;
        if (src_valid && src_ready) begin
          weights_d = src_weights;
          wvalid_d  = 1'b1;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q + 1'b1 == RowCount) begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        // The cycle still carrying the last row is blind to the verdict.
        if (!wvalid_q && recovery_done) begin
          if (recovery_success) begin
            addr_cnt_d = '0;
            state_d    = StReadout;
          end else begin
            fail_d  = 1'b1;
            state_d = StFinish;
          end
        end else if (tmo_cnt_q == TmoLimit) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StReadout: begin
        load_en   = 1'b1;
        read_addr = addr_cnt_q;
        if (addr_cnt_q == AddrLast) begin
          addr_cnt_d = '0;
          state_d    = StFinish;
        end else begin
          addr_cnt_d = addr_cnt_q + 1'b1;
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign alloc_weights      = weights_q;
  assign alloc_weight_valid = wvalid_q;
  assign status_fail        = fail_q;
  assign status_timeout     = timeout_q;

endmodule

// File: tb/tb_bisr_weight_loader.sv
// Scoreboard bench for bisr_weight_loader: accepted rows and expected readout addresses are
// queued as stimulus is driven and checked as the loader emits them.
module tb_bisr_weight_loader;

  localparam int N   = 8;
  localparam int W   = 8;
  localparam int AW  = 3;
  localparam int TMO = 64;
  localparam int RW  = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic          recovery_done = 1'b0;
  logic          recovery_success = 1'b0;
  logic [RW-1:0] src_weights = '0;
  logic          busy, src_ready, alloc_start, alloc_weight_valid, load_en, done;
  logic          status_fail, status_timeout;
  logic [RW-1:0] alloc_weights;
  logic [AW-1:0] read_addr;

  bisr_weight_loader #(
    .SYSTOLIC_SIZE(N),
    .WEIGHT_WIDTH (W),
    .ADDR_WIDTH   (AW),
    .TIMEOUT      (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_weights       (src_weights),
    .alloc_start       (alloc_start),
    .alloc_weights     (alloc_weights),
    .alloc_weight_valid(alloc_weight_valid),
    .recovery_done     (recovery_done),
    .recovery_success  (recovery_success),
    .read_addr         (read_addr),
    .load_en           (load_en),
    .done              (done),
    .status_fail       (status_fail),
    .status_timeout    (status_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            vectors = 0;
  int            miscompares = 0;
  logic [RW-1:0] exp_rows[$];
  int            exp_addr[$];
  logic          acc_q = 1'b0;
  logic [RW-1:0] last_row = '0;
  int            k0 = 0;
  int            n_awv, n_load, n_astart, n_acc;
  int            t_astart, t_ready, t_awv, t_load, t_done;

  // Handshake as seen by the loader at each edge.
  initial forever begin
    @(posedge clk);
    acc_q = rst_n & src_valid & src_ready;
  end

  initial begin : monitor
    logic [RW-1:0] er;
    int            ea;
    int            rel;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_row = '0;
      end else begin
        rel = cyc - k0;
        vectors++;
        if (alloc_weight_valid !== acc_q) begin
          miscompares++;
          $display("FAIL awv_follows_accept @%0d: got %b want %b", rel, alloc_weight_valid, acc_q);
        end
        if (alloc_weight_valid) begin
          n_awv++;
          if (t_awv < 0) t_awv = rel;
          vectors++;
          if (exp_rows.size() == 0) begin
            miscompares++;
            $display("FAIL extra_row @%0d: got %0h want no row", rel, alloc_weights);
          end else begin
            er = exp_rows.pop_front();
            if (alloc_weights !== er) begin
              miscompares++;
              $display("FAIL row_data @%0d: got %0h want %0h", rel, alloc_weights, er);
            end
            last_row = er;
          end
        end else begin
          vectors++;
          if (alloc_weights !== last_row) begin
            miscompares++;
            $display("FAIL weights_hold @%0d: got %0h want %0h", rel, alloc_weights, last_row);
          end
        end
        vectors++;
        if (load_en) begin
          n_load++;
          if (t_load < 0) t_load = rel;
          ea = (exp_addr.size() == 0) ? -1 : exp_addr.pop_front();
          if (int'(read_addr) != ea) begin
            miscompares++;
            $display("FAIL read_addr @%0d: got %0d want %0d", rel, read_addr, ea);
          end
        end else if (read_addr !== '0) begin
          miscompares++;
          $display("FAIL read_addr_idle @%0d: got %0d want 0", rel, read_addr);
        end
        if (alloc_start) begin
          n_astart++;
          if (t_astart < 0) t_astart = rel;
        end
        if (src_ready && t_ready < 0) t_ready = rel;
      end
    end
  end

  // verdict: 0 success, 1 recovery failure, 2 never done
  task automatic run_tile(input bit gap, input int verdict, input bit repulse,
                          input int abort_addr, output bit aborted);
    int  sent;
    int  rel;
    bit  saw_load;
    sent = 0; aborted = 1'b0; saw_load = 1'b0;
    n_awv = 0; n_load = 0; n_astart = 0; n_acc = 0;
    t_astart = -1; t_ready = -1; t_awv = -1; t_load = -1; t_done = -1;
    if (verdict == 0) for (int a = 0; a < N; a++) exp_addr.push_back(a);
    @(negedge clk);
    k0 = cyc;
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rel = cyc - k0;
      if (done) begin
        t_done = rel;
        start = 1'b0; src_valid = 1'b0; recovery_done = 1'b0; recovery_success = 1'b0;
        return;
      end
      if (abort_addr >= 0 && load_en && int'(read_addr) == abort_addr) begin
        rst_n = 1'b0;
        aborted = 1'b1;
        start = 1'b0; src_valid = 1'b0; recovery_done = 1'b0; recovery_success = 1'b0;
        exp_rows.delete();
        exp_addr.delete();
        return;
      end
      start = repulse && (rel == 4 || (load_en && !saw_load));
      if (load_en) saw_load = 1'b1;
      src_weights = {$urandom(), $urandom()};
      src_valid = gap ? cyc[0] : 1'b1;
      if (sent < N) begin
        // Bogus failing verdicts during gaps must be ignored while streaming.
        recovery_done    = gap & ~src_valid;
        recovery_success = 1'b0;
      end else begin
        recovery_done    = (verdict != 2);
        recovery_success = (verdict == 0);
      end
      if (src_valid && src_ready) begin
        exp_rows.push_back(src_weights);
        sent++;
        n_acc++;
      end
    end
    miscompares++;
    $display("FAIL tile_no_done: got no done within 300 cycles want done");
    start = 1'b0; src_valid = 1'b0; recovery_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, src_ready, alloc_start, alloc_weight_valid, load_en, done, status_fail,
         status_timeout, alloc_weights, read_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b as=%b awv=%b le=%b dn=%b sf=%b st=%b w=%0h ra=%0d want all 0",
               busy, src_ready, alloc_start, alloc_weight_valid, load_en, done, status_fail,
               status_timeout, alloc_weights, read_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    bit ab;
    run_tile(1'b0, 0, 1'b0, -1, ab);
    vectors += 10;
    if (t_astart != 1) begin miscompares++; $display("FAIL basic_astart: got %0d want 1", t_astart); end
    if (n_astart != 1) begin miscompares++; $display("FAIL basic_astart_cnt: got %0d want 1", n_astart); end
    if (t_ready != 2) begin miscompares++; $display("FAIL basic_ready: got %0d want 2", t_ready); end
    if (t_awv != 3) begin miscompares++; $display("FAIL basic_first_row: got %0d want 3", t_awv); end
    if (n_awv != 8) begin miscompares++; $display("FAIL basic_rows: got %0d want 8", n_awv); end
    if (t_load != 12) begin miscompares++; $display("FAIL basic_first_load: got %0d want 12", t_load); end
    if (n_load != 8) begin miscompares++; $display("FAIL basic_loads: got %0d want 8", n_load); end
    if (t_done != 20) begin miscompares++; $display("FAIL basic_done: got %0d want 20", t_done); end
    if (status_fail !== 1'b0) begin miscompares++; $display("FAIL basic_status: got %b want 0", status_fail); end
    if (exp_addr.size() != 0) begin miscompares++; $display("FAIL basic_addr_left: got %0d want 0", exp_addr.size()); end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_done_pulse: got done,busy=%b want 00", {done, busy});
    end
  endtask

  task automatic test_gaps();
    bit ab;
    run_tile(1'b1, 0, 1'b0, -1, ab);
    vectors += 4;
    if (n_acc != 8) begin miscompares++; $display("FAIL gaps_accepts: got %0d want 8", n_acc); end
    if (n_awv != 8) begin miscompares++; $display("FAIL gaps_rows: got %0d want 8", n_awv); end
    if (n_load != 8) begin miscompares++; $display("FAIL gaps_loads: got %0d want 8", n_load); end
    if (status_fail !== 1'b0) begin miscompares++; $display("FAIL gaps_status: got %b want 0", status_fail); end
  endtask

  task automatic test_fail();
    bit ab;
    run_tile(1'b0, 1, 1'b0, -1, ab);
    vectors += 4;
    if (n_load != 0) begin miscompares++; $display("FAIL fail_loads: got %0d want 0", n_load); end
    if (t_done != 12) begin miscompares++; $display("FAIL fail_done: got %0d want 12", t_done); end
    if (status_fail !== 1'b1) begin miscompares++; $display("FAIL fail_status: got %b want 1", status_fail); end
    if (status_timeout !== 1'b0) begin miscompares++; $display("FAIL fail_tmo_flag: got %b want 0", status_timeout); end
  endtask

  task automatic test_timeout();
    bit ab;
    run_tile(1'b0, 2, 1'b0, -1, ab);
    vectors += 4;
    if (t_done != 10 + TMO + 1) begin miscompares++; $display("FAIL tmo_done: got %0d want %0d", t_done, 10 + TMO + 1); end
    if (n_load != 0) begin miscompares++; $display("FAIL tmo_loads: got %0d want 0", n_load); end
    if (status_fail !== 1'b1) begin miscompares++; $display("FAIL tmo_status: got %b want 1", status_fail); end
    if (status_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_flag: got %b want 1", status_timeout); end
    run_tile(1'b0, 0, 1'b0, -1, ab);
    vectors += 2;
    if ({status_fail, status_timeout} !== 2'b00) begin
      miscompares++;
      $display("FAIL tmo_clear: got %b want 00", {status_fail, status_timeout});
    end
    if (t_done != 20) begin miscompares++; $display("FAIL tmo_next_done: got %0d want 20", t_done); end
  endtask

  task automatic test_restart();
    bit ab;
    run_tile(1'b0, 0, 1'b1, -1, ab);
    vectors += 4;
    if (n_astart != 1) begin miscompares++; $display("FAIL restart_astart: got %0d want 1", n_astart); end
    if (n_awv != 8) begin miscompares++; $display("FAIL restart_rows: got %0d want 8", n_awv); end
    if (n_load != 8) begin miscompares++; $display("FAIL restart_loads: got %0d want 8", n_load); end
    if (t_done != 20) begin miscompares++; $display("FAIL restart_done: got %0d want 20", t_done); end
  endtask

  task automatic test_reset_mid();
    bit ab;
    run_tile(1'b0, 0, 1'b0, 3, ab);
    #1;
    vectors += 2;
    if (ab !== 1'b1) begin miscompares++; $display("FAIL midrst_reached: got %b want 1", ab); end
    if ({busy, src_ready, alloc_start, alloc_weight_valid, load_en, done, status_fail,
         status_timeout, alloc_weights, read_addr} !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got busy=%b le=%b ra=%0d w=%0h want all 0",
               busy, load_en, read_addr, alloc_weights);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_tile(1'b0, 0, 1'b0, -1, ab);
    vectors += 3;
    if (n_awv != 8) begin miscompares++; $display("FAIL midrst_rows: got %0d want 8", n_awv); end
    if (n_load != 8) begin miscompares++; $display("FAIL midrst_loads: got %0d want 8", n_load); end
    if (t_done != 20) begin miscompares++; $display("FAIL midrst_done: got %0d want 20", t_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_fail();
    test_timeout();
    test_restart();
    test_reset_mid();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_rows.size() != 0) begin
      miscompares++;
      $display("FAIL rows_left: got %0d want 0", exp_rows.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
